// File: rtl/regfile_mp.sv
// Parametrised register file: NREAD combinational read ports, one write port,
// optional hardwired-zero entry, write-to-read bypass and sequenced clear after reset.
module regfile_mp #(
    parameter int unsigned WIDTH          = 64,
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned NREAD          = 2,
    parameter bit          ZERO_EN        = 1'b1,
    parameter int unsigned ZERO_IDX       = 31,
    parameter bit          BYPASS         = 1'b1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      RegWr,
    input  logic [ADDR_W-1:0]         RW,
    input  logic [WIDTH-1:0]          BusW,
    input  logic [NREAD*ADDR_W-1:0]   RA,
    output logic [NREAD*WIDTH-1:0]    BusR,
    output logic                      Busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                clr_we;
    logic                wr_en;
    logic [WIDTH-1:0]    mem [DEPTH];

    // State and clear-counter register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= CLEAR_ON_RESET ? CLEAR : READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: walk every entry once while clearing, then accept writes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_A) begin
                    state_d = READY;
                end
            end
            READY: begin
                wr_en = RegWr && !(ZERO_EN && (RW == ZERO_A));
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

    assign Busy = (state_q == CLEAR);

    // Storage: contents are left alone on a reset edge
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (clr_we) begin
                mem[cnt_q] <= '0;
            end else if (wr_en) begin
                mem[RW] <= BusW;
            end
        end
    end

    // Independent read ports; zero entry outranks bypass so a write to it never leaks
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [WIDTH-1:0]  rd;

        assign ra = RA[i*ADDR_W +: ADDR_W];

        always_comb begin
            rd = mem[ra];
            if (Busy) begin
                rd = '0;
            end else if (ZERO_EN && (ra == ZERO_A)) begin
                rd = '0;
            end else if (BYPASS && RegWr && (ra == RW) && (state_q == READY)) begin
                rd = BusW;
            end
        end

        assign BusR[i*WIDTH +: WIDTH] = rd;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default 2x64 build plus a 4-port 32-bit build.
module tb_regfile_mp;

    logic         clk;
    logic         rst;
    logic         reg_wr;
    logic [4:0]   rw;
    logic [63:0]  bus_w;
    logic [9:0]   ra;
    logic [127:0] bus_r;
    logic         busy;

    logic         rst4;
    logic         reg_wr4;
    logic [4:0]   rw4;
    logic [31:0]  bus_w4;
    logic [19:0]  ra4;
    logic [127:0] bus_r4;
    logic         busy4;

    int n_checks;
    int n_errors;
    int n;

    regfile_mp u_dut (
        .Clk   (clk),
        .Reset (rst),
        .RegWr (reg_wr),
        .RW    (rw),
        .BusW  (bus_w),
        .RA    (ra),
        .BusR  (bus_r),
        .Busy  (busy)
    );

    regfile_mp #(.WIDTH(32), .NREAD(4)) u_dut4 (
        .Clk   (clk),
        .Reset (rst4),
        .RegWr (reg_wr4),
        .RW    (rw4),
        .BusW  (bus_w4),
        .RA    (ra4),
        .BusR  (bus_r4),
        .Busy  (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Count edges until Busy falls on the main instance, bounded
    task automatic wait_clear(output int edges);
        edges = 0;
        while (busy && edges < 200) begin
            tick();
            edges++;
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [63:0] d);
        reg_wr = 1'b1;
        rw     = a;
        bus_w  = d;
        tick();
        reg_wr = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a0);
        ra = {a1, a0};
        #1;
    endtask

    task automatic wr4(input logic [4:0] a, input logic [31:0] d);
        reg_wr4 = 1'b1;
        rw4     = a;
        bus_w4  = d;
        tick();
        reg_wr4 = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;  reg_wr = 1'b0;  rw = '0;  bus_w = '0;  ra = '0;
        rst4 = 1'b1; reg_wr4 = 1'b0; rw4 = '0; bus_w4 = '0; ra4 = '0;

        // Reset edge at t=5, release before the next edge
        @(negedge clk);
        #1;
        check("busy_in_reset", 128'(busy), 128'(1));
        check("rd_zero_busy", bus_r, 128'(0));
        rst  = 1'b0;
        rst4 = 1'b0;
        wait_clear(n);
        check("clear_edges", 128'(n), 128'(32));
        check("busy4_done", 128'(busy4), 128'(0));
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(i));
            check("cleared_entry", bus_r, 128'(0));
        end

        // Same-cycle bypass, then registered value
        reg_wr = 1'b1; rw = 5'd5; bus_w = 64'hDEADBEEF_00000001;
        rd(5'd6, 5'd5);
        check("bypass_p0", bus_r, {64'h0, 64'hDEADBEEF_00000001});
        @(posedge clk);
        @(negedge clk);
        reg_wr = 1'b0;
        #1;
        check("after_write", bus_r, {64'h0, 64'hDEADBEEF_00000001});
        rd(5'd5, 5'd6);
        check("swap_ports", bus_r, {64'hDEADBEEF_00000001, 64'h0});

        // Hardwired zero entry ignores writes and beats the bypass
        wr(5'd30, 64'hAAAA);
        reg_wr = 1'b1; rw = 5'd31; bus_w = 64'hFFFF;
        rd(5'd31, 5'd31);
        check("zero_no_bypass", bus_r, 128'(0));
        tick();
        reg_wr = 1'b0;
        rd(5'd31, 5'd31);
        check("zero_after_wr", bus_r, 128'(0));
        rd(5'd30, 5'd31);
        check("r30_intact", bus_r, {64'hAAAA, 64'h0});

        // Writes held during the clear sequence are dropped
        rst = 1'b1;
        tick();
        rst = 1'b0;
        reg_wr = 1'b1; rw = 5'd7; bus_w = 64'h1234;
        rd(5'd7, 5'd5);
        check("rd_busy_masked", bus_r, 128'(0));
        wait_clear(n);
        reg_wr = 1'b0;
        check("clear2_edges", 128'(n), 128'(32));
        rd(5'd7, 5'd5);
        check("r7_dropped", bus_r, 128'(0));

        // Reset mid-clear restarts the sequence
        wr(5'd20, 64'h20);
        rd(5'd20, 5'd20);
        check("r20_written", bus_r, {64'h20, 64'h20});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        #1;
        check("busy_mid", 128'(busy), 128'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_clear(n);
        check("restart_edges", 128'(n), 128'(32));
        rd(5'd20, 5'd0);
        check("r20_cleared", bus_r, 128'(0));

        // Four-port 32-bit build
        wr4(5'd1, 32'd1);
        wr4(5'd2, 32'd2);
        wr4(5'd3, 32'd3);
        wr4(5'd4, 32'd4);
        ra4 = {5'd4, 5'd3, 5'd2, 5'd1};
        #1;
        check("p4_order", bus_r4, {32'd4, 32'd3, 32'd2, 32'd1});
        ra4 = {5'd2, 5'd2, 5'd2, 5'd2};
        #1;
        check("p4_dup", bus_r4, {32'd2, 32'd2, 32'd2, 32'd2});
        ra4 = {5'd31, 5'd0, 5'd4, 5'd31};
        #1;
        check("p4_zero_mix", bus_r4, {32'd0, 32'd0, 32'd4, 32'd0});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
